// File: rtl/crc_pkg.sv
// Shared definitions for the CRC request scheduler and its engine.
`ifndef DATA_LENGTH
`define DATA_LENGTH 8
`endif
`ifndef CRC_LENGTH
`define CRC_LENGTH 8
`endif

package crc_pkg;

  localparam int unsigned DATA_LENGTH = `DATA_LENGTH;
  localparam int unsigned CRC_LENGTH  = `CRC_LENGTH;
  localparam logic [CRC_LENGTH-1:0] CRC_POLY = CRC_LENGTH'(8'h07);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } sched_state_e;

endpackage

// File: rtl/crc_req_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx,
  output logic               any
);

  // Scan NUM_REQ positions starting at ptr; first hit wins.
  always_comb begin : arb_c
    int unsigned j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      j = 32'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!any && req[IW'(j)]) begin
        any          = 1'b1;
        gnt[IW'(j)]  = 1'b1;
        idx          = IW'(j);
      end
    end
  end

endmodule

// File: rtl/crc_req_sched.sv
// Shares one bit-serial CRC engine between NUM_REQ requesters, round-robin,
// with a watchdog that answers with an error when the engine never finishes.
module crc_req_sched #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DATA_LENGTH = crc_pkg::DATA_LENGTH,
  parameter int unsigned CRC_LENGTH  = crc_pkg::CRC_LENGTH,
  parameter int unsigned TMO_MARGIN  = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_vld,
  input  logic [NUM_REQ*DATA_LENGTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]               req_rdy,
  output logic                             eng_start,
  output logic [DATA_LENGTH-1:0]           eng_data,
  input  logic                             eng_vld,
  input  logic [CRC_LENGTH-1:0]            eng_crc,
  output logic                             resp_vld,
  input  logic                             resp_rdy,
  output logic [$clog2(NUM_REQ)-1:0]       resp_id,
  output logic [CRC_LENGTH-1:0]            resp_crc,
  output logic [DATA_LENGTH-1:0]           resp_data,
  output logic                             resp_err,
  output logic                             busy
);

  import crc_pkg::*;

  localparam int unsigned IW        = $clog2(NUM_REQ);
  localparam int unsigned CW        = $clog2(DATA_LENGTH + TMO_MARGIN + 3);
  localparam int unsigned TMO_LIMIT = DATA_LENGTH + 1 + TMO_MARGIN;
  localparam logic [CW-1:0] CNT_MAX = '1;

  sched_state_e           state;
  logic [IW-1:0]          ptr;
  logic [CW-1:0]          tmo_cnt;
  logic [CW-1:0]          tmo_cnt_inc_c;
  logic [NUM_REQ-1:0]     gnt_c;
  logic [IW-1:0]          gnt_idx_c;
  logic                   gnt_any_c;
  logic [DATA_LENGTH-1:0] sel_data_c;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_arb (
    .req (req_vld),
    .ptr (ptr),
    .gnt (gnt_c),
    .idx (gnt_idx_c),
    .any (gnt_any_c)
  );

  // Accept strobe is only meaningful in IDLE; forced low while in reset.
  assign req_rdy = (state == IDLE && !rst) ? gnt_c : '0;

  // Payload slice of the winning requester.
  always_comb begin
    sel_data_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx_c == IW'(i)) sel_data_c = req_data[i*DATA_LENGTH +: DATA_LENGTH];
    end
  end

  // Saturating watchdog increment; never wraps back to zero.
  always_comb begin
    tmo_cnt_inc_c = (tmo_cnt == CNT_MAX) ? tmo_cnt : tmo_cnt + CW'(1);
  end

  // Scheduler FSM with capture registers and watchdog.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      tmo_cnt   <= '0;
      eng_start <= 1'b0;
      eng_data  <= '0;
      resp_vld  <= 1'b0;
      resp_id   <= '0;
      resp_crc  <= '0;
      resp_data <= '0;
      resp_err  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any_c) begin
            eng_data  <= sel_data_c;
            resp_id   <= gnt_idx_c;
            eng_start <= 1'b1;
            busy      <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          eng_start <= 1'b0;
          tmo_cnt   <= '0;
          state     <= RUN;
        end
        RUN: begin
          tmo_cnt <= tmo_cnt_inc_c;
          // A done pulse wins over a coincident timeout.
          if (eng_vld) begin
            resp_crc  <= eng_crc;
            resp_err  <= 1'b0;
            resp_data <= eng_data;
            resp_vld  <= 1'b1;
            state     <= RESP;
          end else if (tmo_cnt_inc_c == CW'(TMO_LIMIT)) begin
            resp_crc  <= '0;
            resp_err  <= 1'b1;
            resp_data <= eng_data;
            resp_vld  <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (resp_rdy) begin
            resp_vld <= 1'b0;
            busy     <= 1'b0;
            ptr      <= (resp_id == IW'(NUM_REQ - 1)) ? '0 : resp_id + IW'(1);
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_req_sched.sv
// Directed bench for crc_req_sched with a behavioural CRC-8 (poly 0x07) engine.
module tb_crc_req_sched;

  localparam int unsigned DL = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_vld;
  logic [31:0] req_data;
  logic [3:0]  req_rdy;
  logic        eng_start;
  logic [7:0]  eng_data;
  logic        eng_vld;
  logic [7:0]  eng_crc;
  logic        resp_vld;
  logic        resp_rdy;
  logic [1:0]  resp_id;
  logic [7:0]  resp_crc;
  logic [7:0]  resp_data;
  logic        resp_err;
  logic        busy;

  int errors = 0;
  int checks = 0;

  // Engine model state
  logic       model_active = 1'b0;
  int         model_k      = 0;
  logic       model_vld    = 1'b0;
  logic [7:0] model_crc    = 8'h00;
  logic       eng_mute     = 1'b0;
  logic       stray_vld    = 1'b0;
  logic [7:0] stray_crc    = 8'hA5;

  assign eng_vld = model_vld | stray_vld;
  assign eng_crc = stray_vld ? stray_crc : model_crc;

  always #5 clk = ~clk;

  crc_req_sched #(
    .NUM_REQ     (4),
    .DATA_LENGTH (8),
    .CRC_LENGTH  (8),
    .TMO_MARGIN  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_vld   (req_vld),
    .req_data  (req_data),
    .req_rdy   (req_rdy),
    .eng_start (eng_start),
    .eng_data  (eng_data),
    .eng_vld   (eng_vld),
    .eng_crc   (eng_crc),
    .resp_vld  (resp_vld),
    .resp_rdy  (resp_rdy),
    .resp_id   (resp_id),
    .resp_crc  (resp_crc),
    .resp_data (resp_data),
    .resp_err  (resp_err),
    .busy      (busy)
  );

  // MSB-first bit-serial CRC-8, poly 0x07, init 0.
  function automatic logic [7:0] crc8(input logic [7:0] d);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int b = 7; b >= 0; b--) begin
      fb = c[7] ^ d[b];
      c  = {c[6:0], 1'b0};
      if (fb) c = c ^ 8'h07;
    end
    return c;
  endfunction

  // Engine: done pulse DL cycles after the start cycle, unless muted.
  always @(posedge clk) begin
    model_vld <= 1'b0;
    if (eng_start) begin
      model_active <= 1'b1;
      model_k      <= 1;
      model_crc    <= crc8(eng_data);
    end else if (model_active) begin
      if (model_k == DL - 1) begin
        model_vld    <= !eng_mute;
        model_active <= 1'b0;
      end
      model_k <= model_k + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_resp(input int max_cyc, input string tag);
    int n;
    n = 0;
    while (resp_vld !== 1'b1 && n < max_cyc) begin
      step();
      n++;
    end
    chk({tag, "_resp_seen"}, 32'(resp_vld), 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_rdy"},   32'(req_rdy),   32'd0);
    chk({tag, "_eng_start"}, 32'(eng_start), 32'd0);
    chk({tag, "_eng_data"},  32'(eng_data),  32'd0);
    chk({tag, "_resp_vld"},  32'(resp_vld),  32'd0);
    chk({tag, "_resp_id"},   32'(resp_id),   32'd0);
    chk({tag, "_resp_crc"},  32'(resp_crc),  32'd0);
    chk({tag, "_resp_data"}, 32'(resp_data), 32'd0);
    chk({tag, "_resp_err"},  32'(resp_err),  32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
  endtask

  int         exp_id  [5] = '{0, 1, 2, 3, 0};
  logic [7:0] exp_crc [5] = '{8'h77, 8'hEE, 8'h99, 8'hDB, 8'h77};
  logic       seen;

  initial begin
    rst      = 1'b1;
    req_vld  = 4'b0000;
    req_data = 32'h0;
    resp_rdy = 1'b0;

    // Reset state
    step();
    step();
    chk_all_zero("reset");
    req_vld = 4'b1111;
    #1;
    chk("reset_req_rdy_gated", 32'(req_rdy), 32'd0);
    req_vld = 4'b0000;
    rst     = 1'b0;
    step();

    // 1: single request, data 0x01 -> crc 0x07
    req_vld  = 4'b0001;
    req_data = 32'h0000_0001;
    #1;
    chk("t1_req_rdy", 32'(req_rdy), 32'h1);
    chk("t1_start_before", 32'(eng_start), 32'd0);
    step();
    req_vld = 4'b0000;
    chk("t1_req_rdy_drop", 32'(req_rdy), 32'd0);
    chk("t1_eng_start", 32'(eng_start), 32'd1);
    chk("t1_eng_data", 32'(eng_data), 32'h01);
    chk("t1_busy", 32'(busy), 32'd1);
    step();
    chk("t1_start_pulse", 32'(eng_start), 32'd0);
    repeat (7) step();
    chk("t1_resp_early", 32'(resp_vld), 32'd0);
    step();
    chk("t1_resp_vld", 32'(resp_vld), 32'd1);
    chk("t1_resp_id", 32'(resp_id), 32'd0);
    chk("t1_resp_crc", 32'(resp_crc), 32'h07);
    chk("t1_resp_data", 32'(resp_data), 32'h01);
    chk("t1_resp_err", 32'(resp_err), 32'd0);
    resp_rdy = 1'b1;
    step();
    resp_rdy = 1'b0;
    chk("t1_resp_done", 32'(resp_vld), 32'd0);
    chk("t1_idle", 32'(busy), 32'd0);

    // 6a: spurious done pulse in IDLE
    stray_vld = 1'b1;
    step();
    stray_vld = 1'b0;
    chk("t6_idle_busy", 32'(busy), 32'd0);
    chk("t6_idle_resp_vld", 32'(resp_vld), 32'd0);
    chk("t6_idle_resp_crc", 32'(resp_crc), 32'h07);
    step();
    chk("t6_idle_busy2", 32'(busy), 32'd0);

    // 2: all four at once, responses 0,1,2,3,0
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    req_vld  = 4'b1111;
    req_data = 32'h4433_2211;
    resp_rdy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_resp(40, "t2");
      chk("t2_resp_id", 32'(resp_id), 32'(exp_id[k]));
      chk("t2_resp_crc", 32'(resp_crc), 32'(exp_crc[k]));
      chk("t2_resp_err", 32'(resp_err), 32'd0);
      if (k == 4) req_vld = 4'b0000;
      step();
    end
    resp_rdy = 1'b0;

    // 3: backpressure; ptr is 1 so requester 2 wins over 3
    req_vld  = 4'b1100;
    req_data = 32'h0402_0000;
    #1;
    chk("t3_req_rdy", 32'(req_rdy), 32'b0100);
    step();
    req_vld = 4'b1000;
    wait_resp(40, "t3");
    for (int c = 0; c < 10; c++) begin
      chk("t3_hold_vld", 32'(resp_vld), 32'd1);
      chk("t3_hold_id", 32'(resp_id), 32'd2);
      chk("t3_hold_crc", 32'(resp_crc), 32'h0E);
      chk("t3_hold_data", 32'(resp_data), 32'h02);
      chk("t3_hold_err", 32'(resp_err), 32'd0);
      chk("t3_hold_req_rdy", 32'(req_rdy), 32'd0);
      step();
    end
    resp_rdy = 1'b1;
    step();
    chk("t3_after_vld", 32'(resp_vld), 32'd0);
    chk("t3_next_grant", 32'(req_rdy), 32'b1000);
    step();
    req_vld = 4'b0000;
    wait_resp(40, "t3b");
    chk("t3b_resp_id", 32'(resp_id), 32'd3);
    chk("t3b_resp_crc", 32'(resp_crc), 32'h1C);
    step();
    resp_rdy = 1'b0;

    // 4: engine never answers -> timeout 14 cycles after start
    eng_mute = 1'b1;
    req_vld  = 4'b0010;
    req_data = 32'h0000_8000;
    #1;
    chk("t4_req_rdy", 32'(req_rdy), 32'b0010);
    step();
    req_vld = 4'b0000;
    chk("t4_eng_start", 32'(eng_start), 32'd1);
    repeat (13) step();
    chk("t4_tmo_early", 32'(resp_vld), 32'd0);
    step();
    chk("t4_tmo_vld", 32'(resp_vld), 32'd1);
    chk("t4_tmo_err", 32'(resp_err), 32'd1);
    chk("t4_tmo_crc", 32'(resp_crc), 32'h00);
    chk("t4_tmo_id", 32'(resp_id), 32'd1);
    chk("t4_tmo_data", 32'(resp_data), 32'h80);
    resp_rdy = 1'b1;
    step();
    resp_rdy = 1'b0;
    eng_mute = 1'b0;
    req_vld  = 4'b0001;
    req_data = 32'h0000_0080;
    #1;
    chk("t4b_req_rdy", 32'(req_rdy), 32'b0001);
    step();
    req_vld = 4'b0000;
    wait_resp(40, "t4b");
    chk("t4b_resp_crc", 32'(resp_crc), 32'h89);
    chk("t4b_resp_err", 32'(resp_err), 32'd0);

    // 6b: spurious done pulse while holding a response
    stray_vld = 1'b1;
    step();
    stray_vld = 1'b0;
    chk("t6_resp_vld", 32'(resp_vld), 32'd1);
    chk("t6_resp_crc", 32'(resp_crc), 32'h89);
    chk("t6_resp_err", 32'(resp_err), 32'd0);
    resp_rdy = 1'b1;
    step();

    // 5: reset during RUN, engine and stray pulses afterwards are ignored
    req_vld  = 4'b0001;
    req_data = 32'h0000_0003;
    step();
    req_vld = 4'b0000;
    step();
    step();
    chk("t5_busy_run", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk_all_zero("t5_rst");
    step();
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 15; c++) begin
      if (c == 8) stray_vld = 1'b1;
      if (c == 9) stray_vld = 1'b0;
      if (resp_vld !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      step();
    end
    chk("t5_no_response", 32'(seen), 32'd0);
    chk("t5_resp_crc", 32'(resp_crc), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
